// File: rtl/fifo_tx_pkg.sv
// Shared types and line-level constants for the FIFO-fed serial transmitter.
package fifo_tx_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/fifo_tx_baud_gen.sv
// Bit-period timer: bit_tick_o marks the last clock of every BAUD_DIV-cycle bit.
// clear_i restarts the period so a frame's start bit begins on a full period.
module fifo_tx_baud_gen #(
    parameter int BAUD_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clear_i,
    output logic bit_tick_o
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] baud_cnt;

    // Count 0..BAUD_DIV-1 and wrap; a clear restarts the bit period at zero.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            baud_cnt <= '0;
        end else if (clear_i || (baud_cnt == LAST)) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + CW'(1);
        end
    end

    assign bit_tick_o = (baud_cnt == LAST);

endmodule

// File: rtl/fifo_tx_serializer.sv
// Drains the synchronous FIFO one word at a time and sends each word as a
// start bit, WIDTH data bits LSB-first and a stop bit on a registered line.
module fifo_tx_serializer
    import fifo_tx_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int BAUD_DIV = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic             fifo_empty_i,
    input  logic [WIDTH-1:0] fifo_rdata_i,
    output logic             fifo_rd_en_o,
    output logic             tx_o,
    output logic             busy_o,
    output logic             frame_done_o
);

    localparam int BCW = $clog2(WIDTH + 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

    tx_state_t        state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [BCW-1:0]   bit_cnt, bit_cnt_nxt;
    logic             tx_nxt;
    logic             baud_clear;
    logic             bit_tick;

    fifo_tx_baud_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_gen (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .clear_i    (baud_clear),
        .bit_tick_o (bit_tick)
    );

    // State, shift register, bit counter and the line itself; reset forces the line idle at once.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            tx_o    <= LINE_IDLE;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            bit_cnt <= bit_cnt_nxt;
            tx_o    <= tx_nxt;
        end
    end

    // Next-state and strobe logic; the pop is gated by reset so no word is lost while held in reset.
    always_comb begin
        state_nxt    = state;
        shreg_nxt    = shreg;
        bit_cnt_nxt  = bit_cnt;
        tx_nxt       = tx_o;
        fifo_rd_en_o = 1'b0;
        frame_done_o = 1'b0;
        baud_clear   = 1'b0;
        case (state)
            IDLE: begin
                tx_nxt       = LINE_IDLE;
                fifo_rd_en_o = en_i & ~fifo_empty_i & rst_n_i;
                if (fifo_rd_en_o) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                shreg_nxt   = fifo_rdata_i;
                bit_cnt_nxt = '0;
                tx_nxt      = START_BIT;
                baud_clear  = 1'b1;
                state_nxt   = START;
            end
            START: begin
                if (bit_tick) begin
                    tx_nxt    = shreg[0];
                    shreg_nxt = shreg >> 1;
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (bit_cnt == LAST_BIT) begin
                        tx_nxt      = STOP_BIT;
                        bit_cnt_nxt = '0;
                        state_nxt   = STOP;
                    end else begin
                        tx_nxt      = shreg[0];
                        shreg_nxt   = shreg >> 1;
                        bit_cnt_nxt = bit_cnt + BCW'(1);
                    end
                end
            end
            STOP: begin
                if (bit_tick) begin
                    frame_done_o = 1'b1;
                    state_nxt    = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = LINE_IDLE;
            end
        endcase
    end

    assign busy_o = (state != IDLE) | fifo_rd_en_o;

endmodule

// File: tb/tb_fifo_tx_serializer.sv
// Directed bench: instance A (WIDTH=8, BAUD_DIV=2) covers single, back-to-back,
// empty, enable-drop and reset-mid-frame cases; instance B (WIDTH=16, BAUD_DIV=1)
// covers the single-cycle bit period. Inputs change and outputs are sampled on
// the falling edge (sampled #1 after driving), while the DUT acts on the rising edge.
module tb_fifo_tx_serializer;

    logic clk = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // Instance A signals and FIFO model
    logic        rst_n_a = 1'b1;
    logic        en_a = 1'b0;
    logic        empty_a;
    logic [7:0]  rdata_a = '0;
    logic        rd_en_a, tx_a, busy_a, done_a;
    logic [7:0]  mem_a [0:31];
    int          wr_ptr_a = 0;
    int          rd_ptr_a = 0;

    // Instance B signals and FIFO model
    logic        rst_n_b = 1'b1;
    logic        en_b = 1'b0;
    logic        empty_b;
    logic [15:0] rdata_b = '0;
    logic        rd_en_b, tx_b, busy_b, done_b;
    logic [15:0] mem_b [0:7];
    int          wr_ptr_b = 0;
    int          rd_ptr_b = 0;

    always #5 clk = ~clk;

    assign empty_a = (wr_ptr_a == rd_ptr_a);
    assign empty_b = (wr_ptr_b == rd_ptr_b);

    fifo_tx_serializer #(.WIDTH(8), .BAUD_DIV(2)) dut_a (
        .clk_i        (clk),
        .rst_n_i      (rst_n_a),
        .en_i         (en_a),
        .fifo_empty_i (empty_a),
        .fifo_rdata_i (rdata_a),
        .fifo_rd_en_o (rd_en_a),
        .tx_o         (tx_a),
        .busy_o       (busy_a),
        .frame_done_o (done_a)
    );

    fifo_tx_serializer #(.WIDTH(16), .BAUD_DIV(1)) dut_b (
        .clk_i        (clk),
        .rst_n_i      (rst_n_b),
        .en_i         (en_b),
        .fifo_empty_i (empty_b),
        .fifo_rdata_i (rdata_b),
        .fifo_rd_en_o (rd_en_b),
        .tx_o         (tx_b),
        .busy_o       (busy_b),
        .frame_done_o (done_b)
    );

    // FIFO read ports: data appears the cycle after the pop strobe
    always @(posedge clk) begin
        if (rd_en_a) begin
            rdata_a  <= mem_a[rd_ptr_a];
            rd_ptr_a <= rd_ptr_a + 1;
        end
        if (rd_en_b) begin
            rdata_b  <= mem_b[rd_ptr_b];
            rd_ptr_b <= rd_ptr_b + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic push_a(input logic [7:0] word);
        mem_a[wr_ptr_a] = word;
        wr_ptr_a++;
    endtask

    // Expected line level at frame bit position idx: start, LSB-first data, stop
    function automatic logic frame_bit(input logic [15:0] word, input int idx, input int width);
        if (idx == 0) return 1'b0;
        if (idx <= width) return word[idx-1];
        return 1'b1;
    endfunction

    // Entered on the pop cycle (already sampled); checks cycles N+1..N+21 of an 8-bit, 2-cycle-bit frame.
    // When drop_at matches a cycle offset, en_a is released at that cycle.
    task automatic applyStimulus(input logic [7:0] word, input int drop_at);
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk);
            if (c == drop_at) en_a = 1'b0;
            #1;
            if (c == 1) checkOutput($sformatf("a_load_tx_%02h", word), tx_a, 1);
            else checkOutput($sformatf("a_tx_%02h_c%0d", word, c), tx_a, frame_bit({8'h00, word}, (c - 2) / 2, 8));
            checkOutput($sformatf("a_busy_%02h_c%0d", word, c), busy_a, 1);
            checkOutput($sformatf("a_done_%02h_c%0d", word, c), done_a, (c == 21) ? 1 : 0);
            checkOutput($sformatf("a_rden_%02h_c%0d", word, c), rd_en_a, 0);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Reset both instances and check reset values
        @(negedge clk);
        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("rst_tx", tx_a, 1);
        checkOutput("rst_rden", rd_en_a, 0);
        checkOutput("rst_busy", busy_a, 0);
        checkOutput("rst_done", done_a, 0);
        checkOutput("rst_b_tx", tx_b, 1);
        @(negedge clk);
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;

        // Single word 0xA5
        push_a(8'hA5);
        @(negedge clk);
        en_a = 1'b1;
        #1;
        checkOutput("single_pop", rd_en_a, 1);
        checkOutput("single_pop_busy", busy_a, 1);
        applyStimulus(8'hA5, -1);
        @(negedge clk);
        #1;
        checkOutput("single_after_tx", tx_a, 1);
        checkOutput("single_after_busy", busy_a, 0);
        checkOutput("single_after_rden", rd_en_a, 0);

        // Back-to-back 0x01 then 0xFF: two idle-high cycles between frames
        @(negedge clk);
        push_a(8'h01);
        push_a(8'hFF);
        #1;
        checkOutput("b2b_pop1", rd_en_a, 1);
        applyStimulus(8'h01, -1);
        @(negedge clk);
        #1;
        checkOutput("b2b_gap1_tx", tx_a, 1);
        checkOutput("b2b_pop2", rd_en_a, 1);
        applyStimulus(8'hFF, -1);
        @(negedge clk);
        #1;
        checkOutput("b2b_end_busy", busy_a, 0);

        // Empty FIFO with enable held for 50 cycles
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #1;
            checkOutput($sformatf("empty_rden_%0d", i), rd_en_a, 0);
            checkOutput($sformatf("empty_tx_%0d", i), tx_a, 1);
            checkOutput($sformatf("empty_busy_%0d", i), busy_a, 0);
        end

        // Enable dropped mid-DATA of 0x3C with 0x55 queued
        @(negedge clk);
        en_a = 1'b0;
        push_a(8'h3C);
        push_a(8'h55);
        @(negedge clk);
        en_a = 1'b1;
        #1;
        checkOutput("endrop_pop1", rd_en_a, 1);
        applyStimulus(8'h3C, 8);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            checkOutput($sformatf("endrop_hold_rden_%0d", i), rd_en_a, 0);
            checkOutput($sformatf("endrop_hold_busy_%0d", i), busy_a, 0);
            checkOutput($sformatf("endrop_hold_tx_%0d", i), tx_a, 1);
        end
        @(negedge clk);
        en_a = 1'b1;
        #1;
        checkOutput("endrop_pop2", rd_en_a, 1);
        applyStimulus(8'h55, -1);

        // Asynchronous reset during DATA of 0x00, with 0x81 queued behind it
        @(negedge clk);
        push_a(8'h00);
        #1;
        checkOutput("rstmid_pop", rd_en_a, 1);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 4) push_a(8'h81);
        end
        #1;
        checkOutput("rstmid_pre_tx", tx_a, 0);
        #2;
        rst_n_a = 1'b0;
        #1;
        checkOutput("rstmid_tx", tx_a, 1);
        checkOutput("rstmid_busy", busy_a, 0);
        checkOutput("rstmid_done", done_a, 0);
        checkOutput("rstmid_rden", rd_en_a, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checkOutput($sformatf("rstmid_hold_done_%0d", i), done_a, 0);
            checkOutput($sformatf("rstmid_hold_tx_%0d", i), tx_a, 1);
            checkOutput($sformatf("rstmid_hold_rden_%0d", i), rd_en_a, 0);
        end
        @(negedge clk);
        rst_n_a = 1'b1;
        #1;
        checkOutput("rstmid_release_pop", rd_en_a, 1);
        applyStimulus(8'h81, -1);

        // Instance B: 16-bit word 0x8001 at one cycle per bit, 18-cycle frame
        @(negedge clk);
        mem_b[wr_ptr_b] = 16'h8001;
        wr_ptr_b++;
        en_b = 1'b1;
        #1;
        checkOutput("b_pop", rd_en_b, 1);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            #1;
            if (c == 1 || c == 20) checkOutput($sformatf("b_tx_c%0d", c), tx_b, 1);
            else checkOutput($sformatf("b_tx_c%0d", c), tx_b, frame_bit(16'h8001, c - 2, 16));
            checkOutput($sformatf("b_busy_c%0d", c), busy_b, (c == 20) ? 0 : 1);
            checkOutput($sformatf("b_done_c%0d", c), done_b, (c == 19) ? 1 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_tx_serializer.md
Name: fifo_tx_serializer

Overview:
- Read-side consumer for the team's synchronous FIFO.
- Pops WIDTH-bit words through the FIFO read port (rd_en / empty / rdata) and transmits each word as an asynchronous serial frame: start bit, WIDTH data bits LSB-first, stop bit.
- Sits between the FIFO and an off-chip serial line, draining whatever the producer has written.

Parameters:
- WIDTH, 16, data bits per word; must match the FIFO WIDTH.
- BAUD_DIV, 4, clock cycles per serial bit; legal range 1 and up.

Ports:
- clk_i  input  1  system clock; all logic on the rising edge
- rst_n_i  input  1  asynchronous active-low reset
- en_i  input  1  transmit enable; gates new pops only
- fifo_empty_i  input  1  FIFO empty flag
- fifo_rdata_i  input  WIDTH  FIFO read data, valid the cycle after the pop
- fifo_rd_en_o  output  1  FIFO pop strobe, one cycle per word
- tx_o  output  1  serial line, idles high
- busy_o  output  1  high from the pop cycle through the last stop-bit cycle
- frame_done_o  output  1  one-cycle pulse in the last cycle of the stop bit

Behaviour:
- Clock and reset are decided: one clock, clk_i; reset rst_n_i is asynchronous and active-low.
- Reset values:
  - FSM = IDLE, tx_o = 1, fifo_rd_en_o = 0, busy_o = 0, frame_done_o = 0.
  - Shift register, baud counter and bit counter = 0.
- FIFO contract: fifo_rdata_i is valid exactly one cycle after fifo_rd_en_o is high. A pop is never issued while fifo_empty_i = 1.
- FSM states: IDLE, LOAD, START, DATA, STOP.
  - IDLE: fifo_rd_en_o = en_i & ~fifo_empty_i (combinational). When the pop fires -> LOAD.
  - LOAD: capture fifo_rdata_i into the shift register; tx_o <= 0 -> START.
  - START: hold tx_o = 0 for BAUD_DIV cycles -> DATA. On exit, tx_o <= shreg[0].
  - DATA: each bit lasts BAUD_DIV cycles; the shift register shifts right at each bit boundary. After WIDTH bits, tx_o <= 1 -> STOP.
  - STOP: hold tx_o = 1 for BAUD_DIV cycles. frame_done_o is high on the final cycle -> IDLE.
- tx_o is a registered output.
- Timing, pop in cycle N:
  - tx_o falls in cycle N+2.
  - Frame occupies cycles N+2 through N+1+(WIDTH+2)*BAUD_DIV.
  - Back-to-back words: exactly 2 idle-high cycles between a stop bit and the next start bit (IDLE pop cycle + LOAD).
- busy_o = (state != IDLE) | fifo_rd_en_o.
- en_i deasserted mid-frame: the current frame completes normally; no further pops.
- fifo_empty_i rising mid-frame: no effect on the current frame; the FSM waits in IDLE.
- Reset mid-frame: tx_o returns high immediately (asynchronous), FSM -> IDLE, in-flight word discarded, no frame_done_o pulse.
- Counter widths:
  - Baud counter: max(1, $clog2(BAUD_DIV)) bits; counts 0..BAUD_DIV-1. With BAUD_DIV = 1, every cycle is a bit boundary.
  - Bit counter: $clog2(WIDTH+1) bits.
  - No overflow is possible by construction.

Decomposition:
- Package fifo_tx_pkg holds:
  - typedef enum logic [2:0] tx_state_t {IDLE, LOAD, START, DATA, STOP}
  - constants LINE_IDLE = 1'b1, START_BIT = 1'b0, STOP_BIT = 1'b1
- One sub-module, fifo_tx_baud_gen:
  - Parameterised by BAUD_DIV.
  - Inputs: clk_i, rst_n_i, clear_i (pulsed on LOAD).
  - Output: bit_tick_o, high on the last cycle of each bit period.
  - The FSM advances only on bit_tick_o.

Test Plan:
- Single word, WIDTH=8, BAUD_DIV=2, FIFO holds 0xA5; en_i=1 -> fifo_rd_en_o high for 1 cycle. tx_o sequence per 2-cycle bit is 0,1,0,1,0,0,1,0,1,1. frame_done_o pulses once, 21 cycles after the pop.
- Back-to-back: FIFO holds 0x01, 0xFF -> two pops. Exactly 2 high cycles between the first stop bit and the second start bit. Second frame data bits are all 1.
- Empty FIFO with en_i=1 for 50 cycles -> fifo_rd_en_o never asserts; tx_o=1 and busy_o=0 throughout.
- en_i dropped during DATA of word 0x3C with 0x55 still queued -> 0x3C frame completes. No second pop until en_i returns; then 0x55 is sent.
- rst_n_i asserted mid-DATA (asynchronously, between clock edges) -> tx_o=1 that same cycle, busy_o=0, no frame_done_o. After release with the FIFO non-empty, a pop occurs on the first enabled cycle.
- BAUD_DIV=1, WIDTH=16, word 0x8001 -> frame is exactly 18 cycles. Data bit 0 and bit 15 are high, all others low.
